// File: rtl/rvcpu_mem_pkg.sv
// rtl/rvcpu_mem_pkg.sv - shared memory-access encodings for core, LSU, RAM and arbiter
package rvcpu_mem_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant; the last owner loses the next tie
module rr_arb2
  import rvcpu_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_instr,
  input  logic   req_data,
  input  logic   advance,
  input  owner_t owner,
  output owner_t grant
);

  owner_t last_grant;

  // Resetting to INSTR lets the data port win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= INSTR;
    end else if (advance) begin
      last_grant <= owner;
    end
  end

  always_comb begin
    grant = INSTR;
    if (req_instr && req_data) begin
      grant = (last_grant == INSTR) ? DATA : INSTR;
    end else if (req_data) begin
      grant = DATA;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - sequences fetch and load/store requests onto the single-port RAM
module mem_arb
  import rvcpu_mem_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        bus_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_valid,
  output logic        mem_write_valid,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_width,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  arb_state_t    state, state_n;
  owner_t        owner, owner_n, grant;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          any_req, timeout, advance;

  logic [31:0] i_rdata_n, d_rdata_n, mem_addr_n, mem_write_data_n;
  logic [1:0]  mem_width_n;
  logic        i_ready_n, d_ready_n, bus_err_n;
  logic        mem_read_valid_n, mem_write_valid_n;

  assign any_req = i_req | d_read | d_write;
  assign timeout = (wait_cnt == CW'(WAIT_MAX));
  assign advance = (state == RESP);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_instr (i_req),
    .req_data  (d_read | d_write),
    .advance   (advance),
    .owner     (owner),
    .grant     (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = mem_write_valid ? RESP : WAIT;
      WAIT:    if (mem_ready || timeout) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and pulses default low.
  always_comb begin
    owner_n           = owner;
    wait_cnt_n        = wait_cnt;
    i_rdata_n         = i_rdata;
    d_rdata_n         = d_rdata;
    mem_addr_n        = mem_addr;
    mem_width_n       = mem_width;
    mem_write_data_n  = mem_write_data;
    mem_read_valid_n  = 1'b0;
    mem_write_valid_n = 1'b0;
    i_ready_n         = 1'b0;
    d_ready_n         = 1'b0;
    bus_err_n         = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_n = grant;
          if (grant == DATA) begin
            // A simultaneous read and write is treated as a write.
            mem_addr_n        = d_addr;
            mem_width_n       = d_width;
            mem_write_data_n  = d_wdata;
            mem_write_valid_n = d_write;
            mem_read_valid_n  = ~d_write;
          end else begin
            mem_addr_n       = i_addr;
            mem_width_n      = MEM_W;
            mem_write_data_n = '0;
            mem_read_valid_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_write_valid) begin
          i_ready_n = (owner == INSTR);
          d_ready_n = (owner == DATA);
        end
      end
      WAIT: begin
        if (mem_ready || timeout) begin
          i_ready_n = (owner == INSTR);
          d_ready_n = (owner == DATA);
          bus_err_n = ~mem_ready;
          if (owner == DATA) begin
            d_rdata_n = mem_ready ? mem_read_data : '0;
          end else begin
            i_rdata_n = mem_ready ? mem_read_data : '0;
          end
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        wait_cnt_n = '0;
      end
      default: begin
        wait_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner           <= INSTR;
      wait_cnt        <= '0;
      i_rdata         <= '0;
      d_rdata         <= '0;
      i_ready         <= 1'b0;
      d_ready         <= 1'b0;
      bus_err         <= 1'b0;
      mem_addr        <= '0;
      mem_width       <= '0;
      mem_write_data  <= '0;
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
    end else begin
      owner           <= owner_n;
      wait_cnt        <= wait_cnt_n;
      i_rdata         <= i_rdata_n;
      d_rdata         <= d_rdata_n;
      i_ready         <= i_ready_n;
      d_ready         <= d_ready_n;
      bus_err         <= bus_err_n;
      mem_addr        <= mem_addr_n;
      mem_width       <= mem_width_n;
      mem_write_data  <= mem_write_data_n;
      mem_read_valid  <= mem_read_valid_n;
      mem_write_valid <= mem_write_valid_n;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with a byte-lane RAM stand-in
module tb_mem_arb;
  import rvcpu_mem_pkg::*;

  localparam int WM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [1:0]  d_width;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_width;
  logic [31:0] mem_read_data = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arb #(.WAIT_MAX(WM)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_ready         (i_ready),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_width         (d_width),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_ready         (d_ready),
    .bus_err         (bus_err),
    .mem_addr        (mem_addr),
    .mem_read_valid  (mem_read_valid),
    .mem_write_valid (mem_write_valid),
    .mem_write_data  (mem_write_data),
    .mem_width       (mem_width),
    .mem_read_data   (mem_read_data),
    .mem_ready       (mem_ready)
  );

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    case (a)
      8'h10: return 8'h93;
      8'h11: return 8'h00;
      8'h12: return 8'h50;
      8'h13: return 8'h00;
      8'h20: return 8'h44;
      8'h21: return 8'h33;
      8'h22: return 8'h22;
      8'h23: return 8'h11;
      default: return a * 8'd37 + 8'd11;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] w);
    return (w == MEM_B) ? 1 : (w == MEM_H) ? 2 : 4;
  endfunction

  // RAM stand-in: answers a read strobe one cycle later unless muted.
  logic [7:0] ram_mem [256];
  bit         ram_wr  [256];
  bit         mute = 1'b0;

  function automatic logic [7:0] ram_byte(input logic [7:0] a);
    return ram_wr[a] ? ram_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_read_valid && !mute) begin
      logic [31:0] v;
      v = '0;
      for (int n = 0; n < nbytes(mem_width); n++)
        v[8*n +: 8] = ram_byte(mem_addr[7:0] + 8'(n));
      mem_ready     <= 1'b1;
      mem_read_data <= v;
    end
    if (mem_write_valid) begin
      for (int n = 0; n < nbytes(mem_width); n++) begin
        ram_mem[mem_addr[7:0] + 8'(n)] <= mem_write_data[8*n +: 8];
        ram_wr[mem_addr[7:0] + 8'(n)]  <= 1'b1;
      end
    end
  end

  // Reference model state
  logic [7:0]  gold [256];
  bit          last_d;
  logic [31:0] exp_i, exp_d;
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input bit ui, input bit urd, input bit uwr,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [1:0] dw, input logic [31:0] wd);
    bit          ud, win_d, wr, got;
    int          lat, k;
    logic [31:0] ea, val;
    logic [1:0]  ew;
    ud    = urd | uwr;
    win_d = (ui && ud) ? !last_d : ud;
    wr    = win_d && uwr;
    ea    = win_d ? da : ia;
    ew    = win_d ? dw : MEM_W;
    lat   = wr ? 2 : (mute ? WM + 3 : 3);
    i_req = ui; i_addr = ia;
    d_read = urd; d_write = uwr; d_addr = da; d_width = dw; d_wdata = wd;
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); @(negedge clk); k++;
      if (k == 1) begin
        chk({tag, ".rd_strobe"}, {31'd0, mem_read_valid}, {31'd0, !wr});
        chk({tag, ".wr_strobe"}, {31'd0, mem_write_valid}, {31'd0, wr});
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".mem_width"}, {30'd0, mem_width}, {30'd0, ew});
        if (wr) chk({tag, ".mem_wdata"}, mem_write_data, wd);
      end
      got = i_ready | d_ready;
    end
    chk({tag, ".latency"}, k, lat);
    chk({tag, ".i_ready"}, {31'd0, i_ready}, {31'd0, !win_d});
    chk({tag, ".d_ready"}, {31'd0, d_ready}, {31'd0, win_d});
    chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, !wr && mute});
    if (wr) begin
      for (int n = 0; n < nbytes(dw); n++) gold[da[7:0] + 8'(n)] = wd[8*n +: 8];
    end else begin
      val = '0;
      if (!mute)
        for (int n = 0; n < nbytes(ew); n++) val[8*n +: 8] = gold[ea[7:0] + 8'(n)];
      if (win_d) exp_d = val; else exp_i = val;
    end
    chk({tag, ".i_rdata"}, i_rdata, exp_i);
    chk({tag, ".d_rdata"}, d_rdata, exp_d);
    last_d = win_d;
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".ready_drop"}, {30'd0, i_ready, d_ready}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready_err"}, {29'd0, i_ready, d_ready, bus_err}, 32'd0);
    chk({tag, ".strobes"}, {30'd0, mem_read_valid, mem_write_valid}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, ".mem_width"}, {30'd0, mem_width}, 32'd0);
    chk({tag, ".i_rdata"}, i_rdata, 32'd0);
    chk({tag, ".d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_width = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) gold[i] = init_byte(8'(i));
    last_d = 1'b0; exp_i = '0; exp_d = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: D, I, D, I
    for (int r = 0; r < 4; r++)
      txn("contend", 1'b1, 1'b1, 1'b0, 32'h10, 32'h20, MEM_W, 32'd0);

    txn("fetch", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, MEM_W, 32'd0);
    chk("fetch.const", i_rdata, 32'h00500093);

    txn("sb", 1'b0, 1'b0, 1'b1, 32'h0, 32'h21, MEM_B, 32'hAB);
    txn("lw", 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, MEM_W, 32'd0);
    chk("lw.const", d_rdata, 32'h1122AB44);

    txn("rw", 1'b0, 1'b1, 1'b1, 32'h0, 32'h40, MEM_W, 32'h5);
    txn("lw40", 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, MEM_W, 32'd0);
    chk("lw40.const", d_rdata, 32'h5);

    mute = 1'b1;
    txn("timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'h30, MEM_W, 32'd0);
    mute = 1'b0;

    // Reset while the fetch sits in WAIT
    i_req = 1'b1; i_addr = 32'h10;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1; i_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    last_d = 1'b0; exp_i = '0; exp_d = '0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("midreset.no_ready", {30'd0, i_ready, d_ready}, 32'd0);
    end
    txn("post_reset", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, MEM_W, 32'd0);

    for (int r = 0; r < 40; r++) begin
      bit          ui, ud, rd, wrr;
      int          op;
      logic [1:0]  w;
      logic [31:0] da, ia;
      ui = 1'($urandom % 2);
      ud = 1'($urandom % 2);
      if (!ui && !ud) ud = 1'b1;
      op  = int'($urandom % 3);
      rd  = ud && (op != 1);
      wrr = ud && (op != 0);
      w   = 2'($urandom % 3);
      da  = $urandom_range(0, 255);
      if (w == MEM_H) da[0] = 1'b0;
      if (w == MEM_W) da[1:0] = 2'b00;
      ia = {24'd0, 8'($urandom_range(0, 255)) & 8'hFC};
      mute = ($urandom % 8) == 0;
      txn("rand", ui, rd, wrr, ia, da, w, $urandom);
      mute = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter/sequencer sharing the single-port simulation RAM between the instruction-fetch unit and the load/store unit. It accepts one request at a time from either port, drives the RAM's one-cycle `mem_*_valid` strobes, and returns read data with a one-cycle `*_ready` pulse. It sits between the CPU core and `ram`, and is the only master on the RAM port.

## Interface
- `WAIT_MAX`, default 15: maximum cycles spent in WAIT before a read is aborted with an error.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  instruction read request; held until `i_ready`.
- `i_addr`  in  32  fetch address (word access).
- `i_rdata`  out  32  fetch data, valid while `i_ready`=1.
- `i_ready`  out  1  one-cycle completion pulse for fetch.
- `d_read`  in  1  data read request; held until `d_ready`.
- `d_write`  in  1  data write request; held until `d_ready`.
- `d_addr`  in  32  data address.
- `d_width`  in  2  access width: 0=byte, 1=half, 2=word.
- `d_wdata`  in  32  store data (low bits used for byte/half).
- `d_rdata`  out  32  load data, zero-extended, valid while `d_ready`=1.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `bus_err`  out  1  pulses with `*_ready` when a read timed out.
- `mem_addr`  out  32  RAM address.
- `mem_read_valid`  out  1  RAM read strobe.
- `mem_write_valid`  out  1  RAM write strobe.
- `mem_write_data`  out  32  RAM write data.
- `mem_width`  out  2  RAM access width.
- `mem_read_data`  in  32  RAM read data.
- `mem_ready`  in  1  RAM read completion, one cycle after the read strobe.

## Operation
- All outputs are registered and reset to 0. `last_grant` resets to INSTR, so data wins the first contention.
- States: IDLE, ISSUE, WAIT, RESP. On reset the FSM is in IDLE.
- **IDLE:** when any request is present, arbitrate, latch the owner, op, addr, width and wdata into the `mem_*` registers, and go to ISSUE.
  - A single requester is always granted.
  - With both ports requesting, grant the port that was not `last_grant` (round-robin).
  - The instruction port always uses width 2 and op read.
  - If `d_read` and `d_write` are both high, the access is a write and the read is ignored.
- **ISSUE:** exactly one cycle with `mem_read_valid` or `mem_write_valid` high. Next state is WAIT for a read, RESP for a write. Strobes drop to 0 on leaving.
- **WAIT:** wait for `mem_ready`.
  - On `mem_ready`, capture `mem_read_data` into the owner's rdata register and go to RESP.
  - The wait counter increments each WAIT cycle. When it reaches `WAIT_MAX` without `mem_ready`, go to RESP with rdata=0 and `bus_err`=1.
- **RESP:** the owner's ready is high for exactly one cycle, with `bus_err` as set. Update `last_grant` to the owner, return to IDLE, clear the counter.
  - Requests are ignored in RESP. The requester drops or changes its request in the cycle after ready.
- Non-owner outputs stay 0. rdata registers hold their value between transactions.
- `mem_ready` outside WAIT is ignored.
- Width and byte-lane handling, including address low bits, is done by the RAM and passed through unchanged. No sign extension is done here.

## Timing
- Request seen in IDLE at cycle 0.
- Read: strobe in cycle 1, `mem_ready` in cycle 2, `*_ready`/rdata in cycle 3. The next request is accepted in cycle 4.
- Write: strobe in cycle 1, `d_ready` in cycle 2. The next request is accepted in cycle 3.
- Timeout read: `*_ready` with `bus_err` arrives `WAIT_MAX`+2 cycles after the strobe.
- `rst` in any state returns to IDLE at the next edge and clears all outputs, the counter and `last_grant`. A RAM `mem_ready` in flight is then discarded.
- Throughput: at most one transaction per 4 cycles (read) or 3 cycles (write).

## Structure
- Shared package `rvcpu_mem_pkg`:
  - width codes MEM_B=0, MEM_H=1, MEM_W=2, also used by the RAM and LSU;
  - state enum IDLE/ISSUE/WAIT/RESP;
  - owner encoding INSTR=0, DATA=1.
- Sub-module `rr_arb2`: a 2-requester round-robin grant with a `last_grant` register updated on an `advance` input. Everything else is a single FSM in `mem_arb`.

## Test plan
- Lone fetch: RAM word 0x10=0x00500093, `i_req`, `i_addr`=0x10 -> `i_ready` in cycle 3 with `i_rdata`=0x00500093, `d_ready`=0.
- Store byte then load word: `d_write` at 0x21 (width 0, wdata 0xAB) over word 0x11223344 -> `d_ready` in cycle 2; the following load of 0x20 (width 2) returns 0x1122AB44.
- Contention: `i_req` and `d_read` high together from reset -> data served first, fetch second. Repeated contention alternates D, I, D, I.
- Read+write together: `d_read`=`d_write`=1 at 0x40, wdata 0x5 -> only `mem_write_valid` pulses, `d_ready` in cycle 2, and RAM word 0x40=5.
- Timeout: a stub RAM never asserts `mem_ready`, `WAIT_MAX`=3 -> `d_ready`=`bus_err`=1 with `d_rdata`=0 in cycle 6.
- Reset mid-read: assert `rst` in WAIT -> all outputs 0 next cycle, no ready pulse, and a later fetch completes normally in 3 cycles.
